mem_stage: RTL and testbench

- Pipeline stage 4 (MEM) of the MIPS core. It consumes what the EXE stage produces and feeds write-back.
- Contains the EXE/MEM pipeline register, a data-memory access FSM with a req/ack handshake and a timeout counter, big-endian byte-lane alignment, and the MEM/WB pipeline register.
- Drives Adrs_MEM, RegWr_MEM and RegWrite_EXE_MEM toward the forwarding unit, and WB_data, RegWr_WB and RegWrite_MEM_WB toward the register file and forwarding muxes.
- Stalls upstream stages while a memory access is outstanding.

---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/mem_byte_align.sv | 35 +++
 rtl/mem_stage.sv | 118 +++++++++++
 tb/tb_mem_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Holds the access FSM states, control-bundle bit positions and byte-enable patterns.
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // MEM_control bit positions
  localparam int MEMREAD  = 0;
  localparam int MEMWRITE = 1;
  localparam int BYTE     = 2;

  // WB_control bit positions
  localparam int REGWRITE = 0;

  // Byte enables, big-endian: offset 0 is bits [31:24]
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_OFF0 = 4'b1000;
  localparam logic [3:0] BE_OFF1 = 4'b0100;
  localparam logic [3:0] BE_OFF2 = 4'b0010;
  localparam logic [3:0] BE_OFF3 = 4'b0001;

  function automatic logic is_mem_op(input logic [2:0] mem_control);
    return mem_control[MEMREAD] | mem_control[MEMWRITE];
  endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Big-endian byte-lane steering for data memory.
// Builds store lanes/enables and extracts a sign-extended byte on loads.
module mem_byte_align
  import mem_stage_pkg::*;
(
  input  logic        byte_op,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0] lane;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    be        = BE_WORD;
    wdata     = store_data;
    load_data = rdata;
    lane      = rdata[31:24];
    if (byte_op) begin
      wdata = {4{store_data[7:0]}};
      case (offset)
        2'd0: begin be = BE_OFF0; lane = rdata[31:24]; end
        2'd1: begin be = BE_OFF1; lane = rdata[23:16]; end
        2'd2: begin be = BE_OFF2; lane = rdata[15:8];  end
        default: begin be = BE_OFF3; lane = rdata[7:0]; end
      endcase
      load_data = {{24{lane[7]}}, lane};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EXE/MEM register, data-memory req/ack FSM with timeout,
// byte-lane alignment and MEM/WB register. Stalls upstream during an access.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WB_W    = 10,
  parameter int TIMEOUT = 16
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic [31:0]     OUT_ALU32,
  input  logic [31:0]     Rt_data_EXE,
  input  logic [4:0]      RegWr_EXE,
  input  logic [2:0]      MEM_control_EXE,
  input  logic [WB_W-1:0] WB_control_EXE,
  output logic            MEM_stall,
  output logic [31:0]     Adrs_MEM,
  output logic [4:0]      RegWr_MEM,
  output logic            RegWrite_EXE_MEM,
  output logic            Dmem_req,
  output logic            Dmem_we,
  output logic [31:0]     Dmem_adrs,
  output logic [3:0]      Dmem_be,
  output logic [31:0]     Dmem_wdata,
  input  logic [31:0]     Dmem_rdata,
  input  logic            Dmem_ack,
  output logic [31:0]     WB_data,
  output logic [4:0]      RegWr_WB,
  output logic            RegWrite_MEM_WB,
  output logic [WB_W-1:0] WB_control_WB,
  output logic            Bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t          state_q;
  logic [7:0]      cnt_q;
  logic [31:0]     rt_q;
  logic [2:0]      memctl_q;
  logic [WB_W-1:0] wbctl_q;

  logic            in_access;
  logic            timeout;
  logic            complete;
  logic            is_load;
  logic [31:0]     load_data;
  logic [31:0]     mem_result;
  logic [WB_W-1:0] mem_wbctl;

  mem_byte_align u_align (
    .byte_op    (memctl_q[BYTE]),
    .offset     (Adrs_MEM[1:0]),
    .store_data (rt_q),
    .rdata      (Dmem_rdata),
    .be         (Dmem_be),
    .wdata      (Dmem_wdata),
    .load_data  (load_data)
  );

  // An ack in the last allowed cycle still wins over the timeout.
  assign in_access = (state_q == ACCESS);
  assign timeout   = in_access & ~Dmem_ack & (cnt_q == CNT_LAST);
  assign complete  = in_access & (Dmem_ack | timeout);
  assign MEM_stall = in_access & ~complete;
  assign is_load   = memctl_q[MEMREAD] & ~memctl_q[MEMWRITE];

  assign Dmem_req         = in_access;
  assign Dmem_we          = memctl_q[MEMWRITE];
  assign Dmem_adrs        = {Adrs_MEM[31:2], 2'b00};
  assign RegWrite_EXE_MEM = wbctl_q[REGWRITE];
  assign RegWrite_MEM_WB  = WB_control_WB[REGWRITE];

  always_comb begin
    mem_result = Adrs_MEM;
    mem_wbctl  = wbctl_q;
    if (timeout) begin
      mem_result          = '0;
      mem_wbctl[REGWRITE] = 1'b0;
    end else if (in_access && is_load) begin
      mem_result = load_data;
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      Adrs_MEM      <= '0;
      rt_q          <= '0;
      RegWr_MEM     <= '0;
      memctl_q      <= '0;
      wbctl_q       <= '0;
      WB_data       <= '0;
      RegWr_WB      <= '0;
      WB_control_WB <= '0;
      Bus_err       <= 1'b0;
    end else if (!MEM_stall) begin
      Adrs_MEM      <= OUT_ALU32;
      rt_q          <= Rt_data_EXE;
      RegWr_MEM     <= RegWr_EXE;
      memctl_q      <= MEM_control_EXE;
      wbctl_q       <= WB_control_EXE;
      state_q       <= is_mem_op(MEM_control_EXE) ? ACCESS : IDLE;
      cnt_q         <= '0;
      WB_data       <= mem_result;
      RegWr_WB      <= RegWr_MEM;
      WB_control_WB <= mem_wbctl;
      Bus_err       <= timeout;
    end else begin
      // Stalled: hold EXE/MEM, push a bubble into MEM/WB.
      cnt_q         <= cnt_q + 8'd1;
      WB_control_WB <= '0;
      Bus_err       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a write-back scoreboard.
// Expected write-backs are queued at issue and popped when the DUT writes back.
module tb_mem_stage;

  logic        Clk;
  logic        Rst_n;
  logic [31:0] OUT_ALU32;
  logic [31:0] Rt_data_EXE;
  logic [4:0]  RegWr_EXE;
  logic [2:0]  MEM_control_EXE;
  logic [9:0]  WB_control_EXE;
  logic        MEM_stall;
  logic [31:0] Adrs_MEM;
  logic [4:0]  RegWr_MEM;
  logic        RegWrite_EXE_MEM;
  logic        Dmem_req;
  logic        Dmem_we;
  logic [31:0] Dmem_adrs;
  logic [3:0]  Dmem_be;
  logic [31:0] Dmem_wdata;
  logic [31:0] Dmem_rdata;
  logic        Dmem_ack;
  logic [31:0] WB_data;
  logic [4:0]  RegWr_WB;
  logic        RegWrite_MEM_WB;
  logic [9:0]  WB_control_WB;
  logic        Bus_err;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        err;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(.WB_W(10), .TIMEOUT(4)) dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .OUT_ALU32        (OUT_ALU32),
    .Rt_data_EXE      (Rt_data_EXE),
    .RegWr_EXE        (RegWr_EXE),
    .MEM_control_EXE  (MEM_control_EXE),
    .WB_control_EXE   (WB_control_EXE),
    .MEM_stall        (MEM_stall),
    .Adrs_MEM         (Adrs_MEM),
    .RegWr_MEM        (RegWr_MEM),
    .RegWrite_EXE_MEM (RegWrite_EXE_MEM),
    .Dmem_req         (Dmem_req),
    .Dmem_we          (Dmem_we),
    .Dmem_adrs        (Dmem_adrs),
    .Dmem_be          (Dmem_be),
    .Dmem_wdata       (Dmem_wdata),
    .Dmem_rdata       (Dmem_rdata),
    .Dmem_ack         (Dmem_ack),
    .WB_data          (WB_data),
    .RegWr_WB         (RegWr_WB),
    .RegWrite_MEM_WB  (RegWrite_MEM_WB),
    .WB_control_WB    (WB_control_WB),
    .Bus_err          (Bus_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] adrs, input logic [31:0] rt, input logic [2:0] ctl,
                       input logic [4:0] rd, input logic [9:0] wb);
    OUT_ALU32       = adrs;
    Rt_data_EXE     = rt;
    MEM_control_EXE = ctl;
    RegWr_EXE       = rd;
    WB_control_EXE  = wb;
  endtask

  task automatic drive_idle();
    drive(32'h0, 32'h0, 3'b000, 5'd0, 10'h000);
  endtask

  task automatic expect_wb(input logic [31:0] data, input logic [4:0] rd, input logic we, input logic err);
    wb_exp_t e;
    e.data = data;
    e.rd   = rd;
    e.we   = we;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: any write-back or bus error must match the oldest expectation.
  always @(negedge Clk) begin
    if (Rst_n === 1'b1 && (RegWrite_MEM_WB === 1'b1 || Bus_err === 1'b1)) begin
      check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        wb_exp_t e;
        e = sb_q.pop_front();
        check("sb_data", WB_data, e.data);
        check("sb_rd", 32'(RegWr_WB), 32'(e.rd));
        check("sb_we", 32'(RegWrite_MEM_WB), 32'(e.we));
        check("sb_err", 32'(Bus_err), 32'(e.err));
      end
    end
  end

  initial begin
    Rst_n      = 1'b0;
    Dmem_ack   = 1'b0;
    Dmem_rdata = 32'h0;
    drive_idle();
    cyc();
    cyc();
    check("rst_adrs", Adrs_MEM, 32'h0);
    check("rst_wbdata", WB_data, 32'h0);
    check("rst_req", 32'(Dmem_req), 32'd0);
    check("rst_stall", 32'(MEM_stall), 32'd0);
    check("rst_buserr", 32'(Bus_err), 32'd0);

    // Reset during an outstanding access; a late ack must be ignored.
    Rst_n = 1'b1;
    drive(32'h300, 32'h0, 3'b001, 5'd3, 10'h001);
    cyc();
    drive_idle();
    #1;
    check("pre_rst_req", 32'(Dmem_req), 32'd1);
    check("pre_rst_stall", 32'(MEM_stall), 32'd1);
    Rst_n = 1'b0;
    cyc();
    cyc();
    check("rst2_req", 32'(Dmem_req), 32'd0);
    check("rst2_stall", 32'(MEM_stall), 32'd0);
    check("rst2_adrs", Adrs_MEM, 32'h0);
    check("rst2_regwr", 32'(RegWr_MEM), 32'd0);
    check("rst2_regwrite_em", 32'(RegWrite_EXE_MEM), 32'd0);
    check("rst2_wbctl", 32'(WB_control_WB), 32'd0);
    Rst_n      = 1'b1;
    Dmem_ack   = 1'b1;
    Dmem_rdata = 32'hBAD0BAD0;
    #1;
    check("late_ack_req", 32'(Dmem_req), 32'd0);
    cyc();
    Dmem_ack = 1'b0;
    check("late_ack_we", 32'(RegWrite_MEM_WB), 32'd0);
    check("late_ack_data", WB_data, 32'h0);

    // ALU pass-through
    drive(32'h00001234, 32'h0, 3'b000, 5'd5, 10'h001);
    expect_wb(32'h00001234, 5'd5, 1'b1, 1'b0);
    cyc();
    drive_idle();
    check("alu_adrs_mem", Adrs_MEM, 32'h00001234);
    check("alu_regwr_mem", 32'(RegWr_MEM), 32'd5);
    check("alu_regwrite_em", 32'(RegWrite_EXE_MEM), 32'd1);
    check("alu_req", 32'(Dmem_req), 32'd0);
    cyc();
    check("alu_wbdata", WB_data, 32'h00001234);
    check("alu_regwr_wb", 32'(RegWr_WB), 32'd5);
    check("alu_wbctl", 32'(WB_control_WB), 32'h001);
    check("alu_req2", 32'(Dmem_req), 32'd0);

    // Store byte at offset 2, zero-wait
    drive(32'h102, 32'hAABBCC7F, 3'b110, 5'd0, 10'h000);
    cyc();
    drive_idle();
    Dmem_ack = 1'b1;
    #1;
    check("sb_req", 32'(Dmem_req), 32'd1);
    check("sb_adrs", Dmem_adrs, 32'h100);
    check("sb_be", 32'(Dmem_be), 32'b0010);
    check("sb_wdata", Dmem_wdata, 32'h7F7F7F7F);
    check("sb_we_out", 32'(Dmem_we), 32'd1);
    check("sb_stall", 32'(MEM_stall), 32'd0);
    cyc();
    Dmem_ack = 1'b0;
    check("sb_req_done", 32'(Dmem_req), 32'd0);

    // Store word at a misaligned address: low bits dropped
    drive(32'h10E, 32'h11223344, 3'b010, 5'd0, 10'h000);
    cyc();
    drive_idle();
    Dmem_ack = 1'b1;
    #1;
    check("sw_adrs", Dmem_adrs, 32'h10C);
    check("sw_be", 32'(Dmem_be), 32'b1111);
    check("sw_wdata", Dmem_wdata, 32'h11223344);
    cyc();
    Dmem_ack = 1'b0;

    // Load word with ack in the 4th ACCESS cycle
    drive(32'h200, 32'h0, 3'b001, 5'd7, 10'h001);
    expect_wb(32'hDEADBEEF, 5'd7, 1'b1, 1'b0);
    cyc();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lw_stall", 32'(MEM_stall), 32'd1);
      check("lw_req", 32'(Dmem_req), 32'd1);
      check("lw_adrs", Dmem_adrs, 32'h200);
      check("lw_we", 32'(Dmem_we), 32'd0);
      cyc();
      check("lw_bubble", 32'(RegWrite_MEM_WB), 32'd0);
    end
    Dmem_ack   = 1'b1;
    Dmem_rdata = 32'hDEADBEEF;
    #1;
    check("lw_stall_ack", 32'(MEM_stall), 32'd0);
    cyc();
    Dmem_ack = 1'b0;
    check("lw_wbdata", WB_data, 32'hDEADBEEF);
    check("lw_regwrite", 32'(RegWrite_MEM_WB), 32'd1);

    // Load byte, offsets 1 and 3, zero-wait
    drive(32'h201, 32'h0, 3'b101, 5'd4, 10'h001);
    expect_wb(32'hFFFFFF80, 5'd4, 1'b1, 1'b0);
    cyc();
    drive(32'h203, 32'h0, 3'b101, 5'd6, 10'h001);
    expect_wb(32'h00000056, 5'd6, 1'b1, 1'b0);
    Dmem_ack   = 1'b1;
    Dmem_rdata = 32'h12803456;
    #1;
    check("lb1_stall", 32'(MEM_stall), 32'd0);
    cyc();
    drive_idle();
    check("lb1_wbdata", WB_data, 32'hFFFFFF80);
    #1;
    check("lb3_stall", 32'(MEM_stall), 32'd0);
    cyc();
    Dmem_ack = 1'b0;
    check("lb3_wbdata", WB_data, 32'h00000056);

    // Timeout with the next ALU op waiting upstream
    drive(32'h300, 32'h0, 3'b001, 5'd8, 10'h001);
    expect_wb(32'h0, 5'd8, 1'b0, 1'b1);
    cyc();
    drive(32'h000055AA, 32'h0, 3'b000, 5'd9, 10'h001);
    expect_wb(32'h000055AA, 5'd9, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("to_stall", 32'(MEM_stall), 32'd1);
      cyc();
      check("to_bubble", 32'(RegWrite_MEM_WB), 32'd0);
      check("to_no_err", 32'(Bus_err), 32'd0);
    end
    #1;
    check("to_stall_end", 32'(MEM_stall), 32'd0);
    cyc();
    drive_idle();
    check("to_buserr", 32'(Bus_err), 32'd1);
    check("to_wbdata", WB_data, 32'h0);
    check("to_regwrite", 32'(RegWrite_MEM_WB), 32'd0);
    check("to_next_adrs", Adrs_MEM, 32'h000055AA);
    cyc();
    check("to_buserr_pulse", 32'(Bus_err), 32'd0);
    check("to_next_wbdata", WB_data, 32'h000055AA);
    check("to_next_regwrite", 32'(RegWrite_MEM_WB), 32'd1);

    cyc();
    cyc();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
